egress_meta_fifo: RTL and testbench

- Buffers 32-bit egress metadata words from the packet validator (egress stage) until the hw/sw interface consumes them.
- Sits between the egress validator and the hw/sw interface. It decouples per-packet validator output from software polling rate.
- Presents the head entry first-word-fall-through and pops on a one-cycle ack pulse from the interface.
- Counts entries dropped on overflow.

---
 rtl/switch_defs.sv | 16 +
 rtl/egress_meta_fifo_meta_ram.sv | 35 +++
 rtl/egress_meta_fifo.sv | 114 +++++++++++
 tb/tb_egress_meta_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/switch_defs.sv
// ---------------------------------------------------------------------------
// switch_defs : shared switch-wide widths and types
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package switch_defs;

  localparam int META_W            = 32;
  localparam int EGRESS_FIFO_DEPTH = 16;

  typedef logic [META_W-1:0] meta_t;

endpackage

`default_nettype wire

// File: rtl/egress_meta_fifo_meta_ram.sv
// ---------------------------------------------------------------------------
// meta_ram : DEPTH x WIDTH register array, one synchronous write port and
//            one asynchronous read port; contents are not reset
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module meta_ram
  import switch_defs::*;
#(
  parameter int DEPTH  = EGRESS_FIFO_DEPTH,
  parameter int WIDTH  = META_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/egress_meta_fifo.sv
// ---------------------------------------------------------------------------
// egress_meta_fifo : first-word-fall-through buffer for egress metadata with
//                    overflow drop counter. Optional high-water mark output
//                    enabled by defining EGRESS_META_FIFO_HWM_EN.
// Revision         : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module egress_meta_fifo
  import switch_defs::*;
#(
  parameter int DEPTH = EGRESS_FIFO_DEPTH,
  parameter int WIDTH = META_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_in_en,
  input  logic [WIDTH-1:0] fifo_in,
  input  logic             fifo_out_ack,
  input  logic             flush,
  output logic [WIDTH-1:0] fifo_out,
  output logic             fifo_out_valid,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_full,
  output logic [31:0]      drop_count
`ifdef EGRESS_META_FIFO_HWM_EN
  ,
  output logic [CNT_W-1:0] high_water
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] rd_data;
  logic             pop;
  logic             push;
  logic             drop;

  assign fifo_out_valid = (fifo_count != '0);
  assign fifo_full      = (fifo_count == CNT_W'(DEPTH));

  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign pop  = fifo_out_ack && fifo_out_valid;
  assign push = fifo_in_en && (!fifo_full || pop);
  assign drop = fifo_in_en && fifo_full && !pop;

  always_comb begin
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CNT_W'(1);
      2'b01:   count_nxt = fifo_count - CNT_W'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= count_nxt;
      if (drop && (drop_count != 32'hFFFF_FFFF)) begin
        drop_count <= drop_count + 32'd1;
      end
    end
  end

`ifdef EGRESS_META_FIFO_HWM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_water <= '0;
    end else if (flush) begin
      high_water <= '0;
    end else if (count_nxt > high_water) begin
      high_water <= count_nxt;
    end
  end
`endif

  meta_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (PTR_W)
  ) u_meta_ram (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (fifo_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign fifo_out = fifo_out_valid ? rd_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_egress_meta_fifo.sv
// ---------------------------------------------------------------------------
// tb_egress_meta_fifo : directed + randomized checks of egress_meta_fifo
//                       against a queue-based reference model
// Revision            : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_egress_meta_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             fifo_in_en;
  logic [WIDTH-1:0] fifo_in;
  logic             fifo_out_ack;
  logic             flush;
  logic [WIDTH-1:0] fifo_out;
  logic             fifo_out_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic [31:0]      drop_count;
`ifdef EGRESS_META_FIFO_HWM_EN
  logic [CNT_W-1:0] high_water;
`endif

  egress_meta_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_in_en     (fifo_in_en),
    .fifo_in        (fifo_in),
    .fifo_out_ack   (fifo_out_ack),
    .flush          (flush),
    .fifo_out       (fifo_out),
    .fifo_out_valid (fifo_out_valid),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full),
    .drop_count     (drop_count)
`ifdef EGRESS_META_FIFO_HWM_EN
    ,
    .high_water     (high_water)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of stored words plus counters.
  logic [31:0] q[$];
  logic [31:0] m_drops;
  int          m_hw;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("valid", 32'(fifo_out_valid), 32'(q.size() != 0));
    chk("full", 32'(fifo_full), 32'(q.size() == DEPTH));
    chk("head", fifo_out, (q.size() != 0) ? q[0] : 32'h0);
    chk("drops", drop_count, m_drops);
`ifdef EGRESS_META_FIFO_HWM_EN
    chk("hwm", 32'(high_water), 32'(m_hw));
`endif
  endtask

  task automatic model_clear();
    q.delete();
    m_drops = 32'h0;
    m_hw    = 0;
  endtask

  task automatic model_step(input logic en, input logic [31:0] d, input logic ack, input logic fl);
    if (fl) begin
      model_clear();
    end else begin
      if (ack && q.size() > 0) void'(q.pop_front());
      if (en) begin
        if (q.size() < DEPTH) q.push_back(d);
        else if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
      end
      if (q.size() > m_hw) m_hw = q.size();
    end
  endtask

  // Called at posedge+1; inputs stay stable until the next edge.
  task automatic cycle(input logic en, input logic [31:0] d, input logic ack, input logic fl);
    fifo_in_en   = en;
    fifo_in      = d;
    fifo_out_ack = ack;
    flush        = fl;
    model_step(en, d, ack, fl);
    @(posedge clk);
    #1;
    fifo_in_en   = 1'b0;
    fifo_out_ack = 1'b0;
    flush        = 1'b0;
    check_all();
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    fifo_in_en   = 1'b0;
    fifo_in      = '0;
    fifo_out_ack = 1'b0;
    flush        = 1'b0;
    model_clear();

    // Reset and ack-while-empty
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Ordering
    cycle(1'b1, 32'hA1, 1'b0, 1'b0);
    cycle(1'b1, 32'hB2, 1'b0, 1'b0);
    cycle(1'b1, 32'hC3, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Overflow then drain
    for (int i = 0; i < 18; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    repeat (16) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Simultaneous push/pop when full and when empty
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'hFF, 1'b1, 1'b0);
    repeat (16) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h5A5A_1234, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Interleaved traffic across pointer wrap
    repeat (40) cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    repeat (300) cycle(1'($urandom_range(0, 3) != 0), $urandom,
                       1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) == 0));
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with 5 entries held
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_all();

    // High-water mark: fill to 7 then drain
    for (int i = 0; i < 7; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    repeat (7) cycle(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef EGRESS_META_FIFO_HWM_EN
    chk("hwm_final", 32'(high_water), 32'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
